decode_issue: RTL and testbench

Decode-and-issue stage sitting directly upstream of the decode-stage register file. It takes one 32-bit instruction per handshake from fetch and drives the register file's `addr_a`/`addr_b` read ports. A 32-entry scoreboard stalls issue on read-after-write and write-after-write hazards. Each issued instruction reaches execute one cycle later, aligned with the register file's registered `a`/`b` outputs.

---
 rtl/decode_issue.sv | 100 ++++++++++
 tb/tb_decode_issue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage with a 32-entry RAW/WAW scoreboard driving register file read addresses
// Ports: clk, rst (async, active-low); fetch handshake if_valid/if_ready/if_instr;
// regfile reads addr_a/addr_b; EX slot ex_valid/ex_ready/ex_opcode/ex_rd/ex_wr_en/ex_setflags/ex_imm;
// writeback clears wb_valid/wb_addr/wb_flags_valid; scoreboard view pending.
module decode_issue #(
    parameter int FLAGS_REG = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [0:31] if_instr,
    output logic [0:4]  addr_a,
    output logic [0:4]  addr_b,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [0:5]  ex_opcode,
    output logic [0:4]  ex_rd,
    output logic        ex_wr_en,
    output logic        ex_setflags,
    output logic [0:63] ex_imm,
    input  logic        wb_valid,
    input  logic [0:4]  wb_addr,
    input  logic        wb_flags_valid,
    output logic [0:31] pending
);
    localparam logic [0:4] FLAGS = 5'(FLAGS_REG);
    logic        d_valid;
    logic [0:31] d_instr;
    logic [0:4]  ex_ra, ex_rb;
    logic [0:5]  op;
    logic [0:4]  rd, ra, src_b;
    logic        is_rr, is_ri, is_ld, is_st, is_br;
    logic        uses_b, writes, wr_en, setflags, hazard, issue;
    logic [0:31] set_v, clr_v;
    assign op       = d_instr[0:5];
    assign rd       = d_instr[6:10];
    assign ra       = d_instr[11:15];
    assign is_rr    = op[0:1] == 2'b00;
    assign is_ri    = op[0:1] == 2'b01;
    assign is_ld    = op[0:1] == 2'b10 && !op[2];
    assign is_st    = op[0:1] == 2'b10 && op[2];
    assign is_br    = op[0:1] == 2'b11;
    // Branches read the flags register through the b port
    assign src_b    = is_br ? FLAGS : d_instr[16:20];
    assign uses_b   = is_rr || is_st || is_br;
    assign writes   = is_rr || is_ri || is_ld;
    assign wr_en    = writes && rd != FLAGS;
    assign setflags = (is_rr || is_ri) && op[5];
    assign hazard   = pending[ra] || (uses_b && pending[src_b]) || (wr_en && pending[rd]) ||
                      (setflags && pending[FLAGS]);
    assign issue    = d_valid && !hazard && (!ex_valid || ex_ready);
    assign if_ready = !d_valid || issue;
    // Hold the stalled EX operands on the read ports so the registered a/b stay valid
    assign addr_a   = ex_valid && !ex_ready ? ex_ra : ra;
    assign addr_b   = ex_valid && !ex_ready ? ex_rb : src_b;
    always_comb begin
        clr_v = '0;
        set_v = '0;
        if (wb_valid) clr_v[wb_addr] = 1'b1;
        if (wb_flags_valid) clr_v[FLAGS] = 1'b1;
        if (issue && wr_en) set_v[rd] = 1'b1;
        if (issue && setflags) set_v[FLAGS] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid     <= 1'b0;
            d_instr     <= '0;
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_rd       <= '0;
            ex_wr_en    <= 1'b0;
            ex_setflags <= 1'b0;
            ex_imm      <= '0;
            ex_ra       <= '0;
            ex_rb       <= '0;
            pending     <= '0;
        end else begin
            pending <= (pending & ~clr_v) | set_v;
            if (if_valid && if_ready) begin
                d_valid <= 1'b1;
                d_instr <= if_instr;
            end else if (issue) begin
                d_valid <= 1'b0;
            end
            if (issue) begin
                ex_valid    <= 1'b1;
                ex_opcode   <= op;
                ex_rd       <= rd;
                ex_wr_en    <= wr_en;
                ex_setflags <= setflags;
                ex_imm      <= {{53{d_instr[21]}}, d_instr[21:31]};
                ex_ra       <= ra;
                ex_rb       <= src_b;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed self-checking bench for decode_issue
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [0:31] if_instr;
    logic [0:4]  addr_a, addr_b;
    logic        ex_valid;
    logic        ex_ready;
    logic [0:5]  ex_opcode;
    logic [0:4]  ex_rd;
    logic        ex_wr_en;
    logic        ex_setflags;
    logic [0:63] ex_imm;
    logic        wb_valid;
    logic [0:4]  wb_addr;
    logic        wb_flags_valid;
    logic [0:31] pending;
    int checks = 0;
    int passed = 0;

    decode_issue dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .addr_a(addr_a), .addr_b(addr_b), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_setflags(ex_setflags),
        .ex_imm(ex_imm), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_flags_valid(wb_flags_valid),
        .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic logic [0:31] mk(input logic [5:0] op, input int rd, input int ra, input int rb,
                                       input logic [10:0] imm);
        return {op, 5'(rd), 5'(ra), 5'(rb), imm};
    endfunction

    function automatic logic [0:31] pb(input int i);
        logic [0:31] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_flags_valid = 1'b0;
        #2;
        chk("rst_if_ready", if_ready, 1);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_addr_b", addr_b, 0);
        chk("rst_ex_imm", ex_imm, 0);
        @(negedge clk) rst = 1'b1;

        // independent stream
        if_valid = 1'b1; if_instr = mk(6'b000000, 1, 2, 3, 11'h0);
        tick();
        chk("ind_addr_a", addr_a, 2);
        chk("ind_addr_b", addr_b, 3);
        chk("ind_ex_empty", ex_valid, 0);
        chk("ind_if_ready", if_ready, 1);
        if_instr = mk(6'b000000, 4, 5, 6, 11'h0);
        tick();
        chk("ind_ex1_valid", ex_valid, 1);
        chk("ind_ex1_rd", ex_rd, 1);
        chk("ind_ex1_wr", ex_wr_en, 1);
        chk("ind_pend1", pending, pb(1));
        if_valid = 1'b0;
        tick();
        chk("ind_ex2_valid", ex_valid, 1);
        chk("ind_ex2_rd", ex_rd, 4);
        chk("ind_pend2", pending, pb(1) | pb(4));
        tick();
        chk("ind_drain", ex_valid, 0);
        wb_valid = 1'b1; wb_addr = 1;
        tick();
        wb_addr = 4;
        tick();
        wb_valid = 1'b0;
        chk("ind_clear", pending, 0);

        // RAW on r1
        if_valid = 1'b1; if_instr = mk(6'b000000, 1, 2, 3, 11'h0);
        tick();
        if_instr = mk(6'b000000, 7, 1, 2, 11'h0);
        tick();
        if_valid = 1'b0;
        chk("raw_ex_rd", ex_rd, 1);
        chk("raw_stall_ready", if_ready, 0);
        chk("raw_addr_a", addr_a, 1);
        tick();
        chk("raw_still_stall", ex_valid, 0);
        chk("raw_still_ready", if_ready, 0);
        chk("raw_pend", pending, pb(1));
        wb_valid = 1'b1; wb_addr = 1;
        tick();
        wb_valid = 1'b0;
        chk("raw_m_ex", ex_valid, 0);
        chk("raw_m_pend", pending, 0);
        chk("raw_m_ready", if_ready, 1);
        chk("raw_m_addr_a", addr_a, 1);
        tick();
        chk("raw_issue", ex_valid, 1);
        chk("raw_issue_rd", ex_rd, 7);
        chk("raw_issue_pend", pending, pb(7));
        wb_valid = 1'b1; wb_addr = 7;
        tick();
        wb_valid = 1'b0;

        // flags producer then branch
        if_valid = 1'b1; if_instr = mk(6'b000001, 2, 3, 4, 11'h0);
        tick();
        if_instr = mk(6'b110000, 0, 5, 9, 11'h0);
        tick();
        if_valid = 1'b0;
        chk("flg_setflags", ex_setflags, 1);
        chk("flg_pend", pending, pb(2) | pb(30));
        chk("flg_stall", if_ready, 0);
        chk("flg_addr_b", addr_b, 30);
        tick();
        chk("flg_still", ex_valid, 0);
        wb_flags_valid = 1'b1;
        tick();
        wb_flags_valid = 1'b0;
        chk("flg_m_pend", pending, pb(2));
        chk("flg_m_ready", if_ready, 1);
        chk("flg_m_addr_b", addr_b, 30);
        chk("flg_m_addr_a", addr_a, 5);
        tick();
        chk("flg_br_valid", ex_valid, 1);
        chk("flg_br_op", ex_opcode, 6'b110000);
        chk("flg_br_wr", ex_wr_en, 0);
        chk("flg_br_sf", ex_setflags, 0);
        wb_valid = 1'b1; wb_addr = 2;
        tick();
        wb_valid = 1'b0;

        // reg-imm into r30 suppressed, reader of r30 not stalled
        if_valid = 1'b1; if_instr = mk(6'b010000, 30, 1, 0, 11'h400);
        tick();
        if_instr = mk(6'b000000, 5, 30, 1, 11'h0);
        tick();
        if_valid = 1'b0;
        chk("r30_rd", ex_rd, 30);
        chk("r30_wr", ex_wr_en, 0);
        chk("r30_pend", pending, 0);
        chk("r30_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FC00);
        chk("r30_ready", if_ready, 1);
        tick();
        chk("r30_reader_valid", ex_valid, 1);
        chk("r30_reader_rd", ex_rd, 5);
        chk("r30_reader_pend", pending, pb(5));
        wb_valid = 1'b1; wb_addr = 5;
        tick();
        wb_valid = 1'b0;

        // execute stall holds operands
        if_valid = 1'b1; if_instr = mk(6'b000000, 10, 5, 6, 11'h3);
        tick();
        if_instr = mk(6'b100000, 11, 9, 0, 11'h0);
        tick();
        if_valid = 1'b0; ex_ready = 1'b0;
        #1;
        chk("exs_addr_a", addr_a, 5);
        chk("exs_addr_b", addr_b, 6);
        chk("exs_ready", if_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("exs_hold_valid", ex_valid, 1);
            chk("exs_hold_rd", ex_rd, 10);
            chk("exs_hold_imm", ex_imm, 3);
            chk("exs_hold_a", addr_a, 5);
            chk("exs_hold_b", addr_b, 6);
        end
        ex_ready = 1'b1;
        #1;
        chk("exs_rel_addr_a", addr_a, 9);
        chk("exs_rel_ready", if_ready, 1);
        tick();
        chk("exs_issue_valid", ex_valid, 1);
        chk("exs_issue_rd", ex_rd, 11);
        chk("exs_issue_op", ex_opcode, 6'b100000);
        chk("exs_pend", pending, pb(10) | pb(11));

        // asynchronous reset with D, EX and scoreboard busy
        if_valid = 1'b1; if_instr = mk(6'b000000, 12, 1, 2, 11'h0);
        tick();
        if_instr = mk(6'b000000, 13, 3, 4, 11'h0);
        tick();
        if_valid = 1'b0; ex_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_pending", pending, 0);
        chk("arst_if_ready", if_ready, 1);
        chk("arst_addr_a", addr_a, 0);
        chk("arst_addr_b", addr_b, 0);
        chk("arst_ex_rd", ex_rd, 0);
        @(negedge clk);
        rst = 1'b1; ex_ready = 1'b1;
        if_valid = 1'b1; if_instr = mk(6'b000000, 1, 2, 3, 11'h0);
        tick();
        if_valid = 1'b0;
        tick();
        chk("post_valid", ex_valid, 1);
        chk("post_rd", ex_rd, 1);
        chk("post_pend", pending, pb(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
